// File: rtl/psg_bus_pkg.sv
// psg_bus_pkg: shared types and bus constants for the PSG bus master
// Define PSG_READBACK_EN to add the rd bit to queued requests.
package psg_bus_pkg;
  typedef enum logic [2:0] {IDLE, SEL, SGAP, ADDR, AGAP, XFER, XGAP} state_t;
  localparam logic [7:0] SEL_CMD_BASE = 8'hFE;
  localparam logic [1:0] BUS_IDLE = 2'b00;
  localparam logic [1:0] BUS_WR = 2'b10;
  localparam logic [1:0] BUS_RD = 2'b01;
  localparam logic [1:0] BUS_LATCH = 2'b11;
  typedef struct packed {
    logic chip;
    logic [3:0] addr;
    logic [7:0] data;
`ifdef PSG_READBACK_EN
    logic rd;
`endif
  } req_t;
endpackage

// File: rtl/psg_req_fifo.sv
// psg_req_fifo: request queue of FIFO_DEPTH entries (power of 2)
// Ports: CLK, RESET (async, active-high), push/din, pop/dout, full, empty, count.
module psg_req_fifo
  import psg_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic push,
  input  req_t din,
  input  logic pop,
  output req_t dout,
  output logic full,
  output logic empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  req_t mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + AW'(1) : wp;
      rp <= do_pop ? rp + AW'(1) : rp;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge CLK)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/psg_bus_master.sv
// psg_bus_master: turns queued PSG register accesses into BDIR/BC/DA cycles for a TurboSound pair
// Ports: CLK, RESET (async, active-high), CE (PSG clock-enable), REQ_* request port,
//   RSP_* read response, BDIR/BC/DA_OUT/DA_IN PSG bus, BUSY.
// Define PSG_READBACK_EN to add REQ_RD/RSP_VALID/RSP_DATA and read transfers.
module psg_bus_master
  import psg_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PHASE_CE = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_CHIP,
  input  logic [3:0] REQ_REG,
  input  logic [7:0] REQ_DATA,
`ifdef PSG_READBACK_EN
  input  logic       REQ_RD,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
`endif
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] DA_OUT,
  input  logic [7:0] DA_IN,
  output logic       BUSY
);
  state_t state, nxt_state;
  logic [3:0] cnt, nxt_cnt;
  logic cur_chip, full, empty, pop, last, cur_rd;
  req_t cur, head, new_req;
  logic [$clog2(FIFO_DEPTH):0] unused_count;
`ifdef PSG_READBACK_EN
  assign new_req = '{chip: REQ_CHIP, addr: REQ_REG, data: REQ_DATA, rd: REQ_RD};
  assign cur_rd = cur.rd;
`else
  assign new_req = '{chip: REQ_CHIP, addr: REQ_REG, data: REQ_DATA};
  assign cur_rd = 1'b0;
`endif
  // Gated by RESET so no request is taken while the queue is held cleared
  assign REQ_READY = !RESET && !full;
  assign BUSY = state != IDLE || !empty;
  psg_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK), .RESET(RESET), .push(REQ_VALID && REQ_READY), .din(new_req),
    .pop(pop), .dout(head), .full(full), .empty(empty), .count(unused_count)
  );
  always_comb begin
    last = cnt == 4'(PHASE_CE - 1);
    nxt_state = state;
    nxt_cnt = cnt;
    pop = 1'b0;
    if (CE)
      case (state)
        IDLE: if (!empty) begin
          pop = 1'b1;
          nxt_state = head.chip != cur_chip ? SEL : ADDR;
        end
        SEL, ADDR, XFER: begin
          nxt_cnt = last ? 4'd0 : cnt + 4'd1;
          nxt_state = !last ? state : state == SEL ? SGAP : state == ADDR ? AGAP : XGAP;
        end
        SGAP: nxt_state = ADDR;
        AGAP: nxt_state = XFER;
        default: nxt_state = IDLE;
      endcase
  end
  // Bus outputs decode straight from state so RESET idles the bus without waiting for CLK
  assign {BDIR, BC} = state inside {SEL, ADDR} ? BUS_LATCH :
                      state == XFER ? (cur_rd ? BUS_RD : BUS_WR) : BUS_IDLE;
  assign DA_OUT = state == SEL ? SEL_CMD_BASE | {7'd0, cur.chip} :
                  state == ADDR ? {4'h0, cur.addr} :
                  state == XFER && !cur_rd ? cur.data : 8'h00;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      cur_chip <= 1'b1;
      cur <= '0;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
      if (pop) cur <= head;
      if (CE && state == SEL && last) cur_chip <= cur.chip;
    end
`ifdef PSG_READBACK_EN
  logic capture;
  assign capture = CE && state == XFER && last && cur_rd;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      RSP_VALID <= 1'b0;
      RSP_DATA <= 8'h00;
    end else begin
      RSP_VALID <= capture;
      if (capture) RSP_DATA <= DA_IN;
    end
`else
  logic unused_da;
  assign unused_da = ^DA_IN;
`endif
endmodule
